bill_acceptor: RTL and testbench

Front-end stage feeding the ticket machine FSM. It debounces the bill-slot sensor and validates the denomination code. It then emits exactly one single-cycle `ten` or `twenty` pulse per accepted bill, drives the mechanism's accept/reject solenoids, and keeps a saturating running total of accepted value in units of 10.

---
 rtl/bill_acceptor.sv | 126 ++++++++++++
 tb/tb_bill_acceptor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bill_acceptor.sv
// Bill-slot front end: debounces the sensor, validates the denomination and
// emits one ten/twenty pulse per accepted bill while keeping a saturating total.
module bill_acceptor #(
    parameter int DEBOUNCE      = 4,
    parameter int REJECT_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             bill_in,
    input  logic [1:0]       bill_code,
    input  logic             dispense,
    input  logic             return_sig,
    output logic             ten,
    output logic             twenty,
    output logic             accept,
    output logic             reject,
    output logic [CNT_W-1:0] total
);

    // state    | meaning
    // IDLE     | slot empty, waiting for bill_in
    // SETTLE   | debouncing; cnt edges seen with a stable code
    // DECIDE   | one cycle; busy flags and code checked on exit
    // ACCEPT   | one cycle; accept plus ten/twenty pulse, total bumped on exit
    // REJECT   | eject solenoid held for REJECT_CYCLES cycles
    // DRAIN    | wait for the slot to empty so a bill is counted once
    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_DECIDE, S_ACCEPT, S_REJECT, S_DRAIN
    } state_t;

    localparam int DB_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
    localparam int RJ_W = (REJECT_CYCLES < 2) ? 1 : $clog2(REJECT_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE);
    localparam logic [RJ_W-1:0] RJ_LAST = RJ_W'(REJECT_CYCLES - 1);

    state_t           r_state, w_state_nxt;
    logic [DB_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [1:0]       r_code, w_code_nxt;
    logic [RJ_W-1:0]  r_rej_cnt, w_rej_nxt;
    logic [CNT_W-1:0] r_total, w_total_nxt;
    logic [CNT_W:0]   w_sum;
    logic             w_code_bad;

    assign w_cnt_inc  = r_cnt + DB_W'(1);
    assign w_code_bad = (r_code != 2'b01) && (r_code != 2'b10);
    // One extra bit catches the carry so the total can clamp at all-ones.
    assign w_sum      = {1'b0, r_total} +
                        ((r_code == 2'b10) ? (CNT_W+1)'(2) : (CNT_W+1)'(1));

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_code    <= 2'b00;
            r_rej_cnt <= '0;
            r_total   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_code    <= w_code_nxt;
            r_rej_cnt <= w_rej_nxt;
            r_total   <= w_total_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_code;
        w_rej_nxt   = r_rej_cnt;
        w_total_nxt = r_total;
        case (r_state)
            S_IDLE: begin
                if (bill_in) begin
                    w_code_nxt  = bill_code;
                    w_cnt_nxt   = DB_W'(1);
                    w_state_nxt = (DEBOUNCE == 1) ? S_DECIDE : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!bill_in) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (bill_code != r_code) begin
                    w_code_nxt = bill_code;
                    w_cnt_nxt  = DB_W'(1);
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == DB_LAST)
                        w_state_nxt = S_DECIDE;
                end
            end
            S_DECIDE: begin
                w_cnt_nxt = '0;
                w_rej_nxt = '0;
                if (dispense || return_sig || w_code_bad)
                    w_state_nxt = S_REJECT;
                else
                    w_state_nxt = S_ACCEPT;
            end
            S_ACCEPT: begin
                w_total_nxt = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
                w_state_nxt = S_DRAIN;
            end
            S_REJECT: begin
                if (r_rej_cnt == RJ_LAST)
                    w_state_nxt = S_DRAIN;
                else
                    w_rej_nxt = r_rej_cnt + RJ_W'(1);
            end
            S_DRAIN: begin
                if (!bill_in)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign accept = (r_state == S_ACCEPT);
    assign ten    = (r_state == S_ACCEPT) && (r_code == 2'b01);
    assign twenty = (r_state == S_ACCEPT) && (r_code == 2'b10);
    assign reject = (r_state == S_REJECT);
    assign total  = r_total;

endmodule

// File: tb/tb_bill_acceptor.sv
// Bench for bill_acceptor: three instances (default, 4-bit total, DEBOUNCE=1)
// share one stimulus; expectations come from per-bill timing arithmetic.
module tb_bill_acceptor;

    localparam int D_A [3] = '{4, 4, 1};
    localparam int R_A [3] = '{8, 8, 1};
    localparam int W_A [3] = '{16, 4, 16};

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        bill_in = 1'b0;
    logic [1:0]  bill_code = 2'b00;
    logic        dispense = 1'b0;
    logic        return_sig = 1'b0;
    logic [2:0]  o_ten, o_tw, o_acc, o_rej;
    logic [15:0] tot [3];
    logic [3:0]  tot_w4;

    int checks = 0;
    int failures = 0;
    int mt [3];

    always #5 clk = ~clk;

    bill_acceptor #(.DEBOUNCE(4), .REJECT_CYCLES(8), .CNT_W(16)) dut0 (
        .clk(clk), .clear(clear), .bill_in(bill_in), .bill_code(bill_code),
        .dispense(dispense), .return_sig(return_sig), .ten(o_ten[0]),
        .twenty(o_tw[0]), .accept(o_acc[0]), .reject(o_rej[0]), .total(tot[0]));
    bill_acceptor #(.DEBOUNCE(4), .REJECT_CYCLES(8), .CNT_W(4)) dut1 (
        .clk(clk), .clear(clear), .bill_in(bill_in), .bill_code(bill_code),
        .dispense(dispense), .return_sig(return_sig), .ten(o_ten[1]),
        .twenty(o_tw[1]), .accept(o_acc[1]), .reject(o_rej[1]), .total(tot_w4));
    bill_acceptor #(.DEBOUNCE(1), .REJECT_CYCLES(1), .CNT_W(16)) dut2 (
        .clk(clk), .clear(clear), .bill_in(bill_in), .bill_code(bill_code),
        .dispense(dispense), .return_sig(return_sig), .ten(o_ten[2]),
        .twenty(o_tw[2]), .accept(o_acc[2]), .reject(o_rej[2]), .total(tot[2]));

    assign tot[1] = {12'd0, tot_w4};

    function automatic int sat(input int t, input int inc, input int w);
        int m;
        m = (1 << w) - 1;
        return (t + inc > m) ? m : t + inc;
    endfunction

    task automatic apply_clear();
        bill_in = 1'b0; dispense = 1'b0; return_sig = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 3; i++) mt[i] = 0;
    endtask

    // One bill: high for n edges, optional code change at edge chg, optional
    // busy flag at edge busy_edge; checks every cycle until all instances idle.
    task automatic run_bill(input string nm, input logic [1:0] code, input int n,
                            input int chg, input logic [1:0] ncode,
                            input int busy_edge, input bit busy_ret);
        int s [3]; int x [3]; bit acc [3]; bit rej [3]; logic [1:0] fc [3];
        int win; int et; bit bad;
        logic e_ten, e_tw, e_acc, e_rej;
        win = n;
        for (int i = 0; i < 3; i++) begin
            s[i]   = (chg > 0 && chg < D_A[i] && ncode != code) ? chg : 0;
            x[i]   = s[i] + D_A[i];
            fc[i]  = (s[i] > 0) ? ncode : code;
            bad    = (fc[i] != 2'b01 && fc[i] != 2'b10) || (busy_edge == x[i]);
            acc[i] = (n >= x[i]) && !bad;
            rej[i] = (n >= x[i]) && bad;
            if (x[i] + R_A[i] + 1 > win) win = x[i] + R_A[i] + 1;
        end
        win += 2;
        for (int k = 0; k < win; k++) begin
            bill_in    = (k < n);
            bill_code  = (chg >= 0 && k >= chg) ? ncode : code;
            dispense   = (k == busy_edge) && !busy_ret;
            return_sig = (k == busy_edge) && busy_ret;
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                e_acc = acc[i] && (k == x[i]);
                e_ten = e_acc && (fc[i] == 2'b01);
                e_tw  = e_acc && (fc[i] == 2'b10);
                e_rej = rej[i] && (k >= x[i]) && (k < x[i] + R_A[i]);
                et    = (acc[i] && k >= x[i] + 1) ?
                        sat(mt[i], (fc[i] == 2'b10) ? 2 : 1, W_A[i]) : mt[i];
                checks += 5;
                if (o_ten[i] !== e_ten) begin failures++;
                    $display("FAIL %s ten inst%0d k=%0d got %b exp %b", nm, i, k, o_ten[i], e_ten); end
                if (o_tw[i] !== e_tw) begin failures++;
                    $display("FAIL %s twenty inst%0d k=%0d got %b exp %b", nm, i, k, o_tw[i], e_tw); end
                if (o_acc[i] !== e_acc) begin failures++;
                    $display("FAIL %s accept inst%0d k=%0d got %b exp %b", nm, i, k, o_acc[i], e_acc); end
                if (o_rej[i] !== e_rej) begin failures++;
                    $display("FAIL %s reject inst%0d k=%0d got %b exp %b", nm, i, k, o_rej[i], e_rej); end
                if (tot[i] !== 16'(et)) begin failures++;
                    $display("FAIL %s total inst%0d k=%0d got %0d exp %0d", nm, i, k, tot[i], et); end
            end
        end
        for (int i = 0; i < 3; i++)
            if (acc[i]) mt[i] = sat(mt[i], (fc[i] == 2'b10) ? 2 : 1, W_A[i]);
        bill_in = 1'b0; dispense = 1'b0; return_sig = 1'b0;
    endtask

    task automatic test_reset();
        #1 clear = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if ({o_ten[i], o_tw[i], o_acc[i], o_rej[i]} !== 4'b0000) begin failures++;
                $display("FAIL reset outputs inst%0d got %b exp 0000", i,
                         {o_ten[i], o_tw[i], o_acc[i], o_rej[i]}); end
            if (tot[i] !== 16'd0) begin failures++;
                $display("FAIL reset total inst%0d got %0d exp 0", i, tot[i]); end
        end
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 3; i++) mt[i] = 0;
    endtask

    task automatic test_accept();
        run_bill("accept_ten", 2'b01, 10, -1, 2'b00, -1, 1'b0);
        run_bill("accept_twenty", 2'b10, 7, -1, 2'b00, -1, 1'b0);
    endtask

    task automatic test_code_change();
        run_bill("code_change", 2'b01, 9, 2, 2'b10, -1, 1'b0);
    endtask

    task automatic test_glitch();
        run_bill("glitch3", 2'b01, 3, -1, 2'b00, -1, 1'b0);
        run_bill("glitch_after_change", 2'b10, 5, 3, 2'b01, -1, 1'b0);
    endtask

    task automatic test_reject();
        run_bill("reject_invalid", 2'b11, 6, -1, 2'b00, -1, 1'b0);
        run_bill("reject_zero", 2'b00, 6, -1, 2'b00, -1, 1'b0);
        run_bill("reject_dispense", 2'b01, 6, -1, 2'b00, 4, 1'b0);
        run_bill("reject_return", 2'b10, 6, -1, 2'b00, 4, 1'b1);
        run_bill("busy_early", 2'b01, 6, -1, 2'b00, 2, 1'b0);
    endtask

    // Two bills at the minimum spacing: one low edge between them in DRAIN.
    task automatic test_back_to_back();
        int et; logic e_p;
        bill_code = 2'b01;
        for (int k = 0; k < 16; k++) begin
            bill_in = (k <= 5) || (k >= 7 && k <= 12);
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                e_p = (k == D_A[i]) || (k == 7 + D_A[i]);
                et  = mt[i];
                if (k >= D_A[i] + 1) et = sat(et, 1, W_A[i]);
                if (k >= D_A[i] + 8) et = sat(et, 1, W_A[i]);
                checks += 2;
                if (o_ten[i] !== e_p) begin failures++;
                    $display("FAIL b2b ten inst%0d k=%0d got %b exp %b", i, k, o_ten[i], e_p); end
                if (tot[i] !== 16'(et)) begin failures++;
                    $display("FAIL b2b total inst%0d k=%0d got %0d exp %0d", i, k, tot[i], et); end
            end
        end
        for (int i = 0; i < 3; i++) mt[i] = sat(sat(mt[i], 1, W_A[i]), 1, W_A[i]);
        bill_in = 1'b0;
    endtask

    task automatic test_clear_accept();
        bill_code = 2'b01; bill_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        checks += 2;
        if (o_ten[0] !== 1'b1) begin failures++;
            $display("FAIL pre_clear ten got %b exp 1", o_ten[0]); end
        if (o_acc[0] !== 1'b1) begin failures++;
            $display("FAIL pre_clear accept got %b exp 1", o_acc[0]); end
        #2 clear = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks += 2;
            if ({o_ten[i], o_acc[i], o_tw[i], o_rej[i]} !== 4'b0000) begin failures++;
                $display("FAIL async_clear outputs inst%0d got %b exp 0000", i,
                         {o_ten[i], o_acc[i], o_tw[i], o_rej[i]}); end
            if (tot[i] !== 16'd0) begin failures++;
                $display("FAIL async_clear total inst%0d got %0d exp 0", i, tot[i]); end
        end
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        for (int k = 0; k < 16; k++) begin
            bill_in = (k < 6);
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checks += 3;
                if (o_ten[i] !== (k == D_A[i])) begin failures++;
                    $display("FAIL post_clear ten inst%0d k=%0d got %b", i, k, o_ten[i]); end
                if (o_acc[i] !== (k == D_A[i])) begin failures++;
                    $display("FAIL post_clear accept inst%0d k=%0d got %b", i, k, o_acc[i]); end
                if (tot[i] !== ((k >= D_A[i] + 1) ? 16'd1 : 16'd0)) begin failures++;
                    $display("FAIL post_clear total inst%0d k=%0d got %0d", i, k, tot[i]); end
            end
        end
        for (int i = 0; i < 3; i++) mt[i] = 1;
        bill_in = 1'b0;
    endtask

    task automatic test_saturation();
        apply_clear();
        for (int b = 0; b < 9; b++)
            run_bill("saturate", 2'b10, 6, -1, 2'b00, -1, 1'b0);
        checks += 2;
        if (tot[1] !== 16'd15) begin failures++;
            $display("FAIL sat_final total4 got %0d exp 15", tot[1]); end
        if (tot[0] !== 16'd18) begin failures++;
            $display("FAIL sat_final total16 got %0d exp 18", tot[0]); end
    endtask

    task automatic test_random();
        logic [1:0] c, nc; int n, chg, be; bit br;
        for (int b = 0; b < 40; b++) begin
            c   = 2'($urandom_range(0, 3));
            nc  = 2'($urandom_range(0, 3));
            n   = $urandom_range(1, 14);
            chg = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : -1;
            be  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 8) : -1;
            br  = 1'($urandom_range(0, 1));
            run_bill("random", c, n, chg, nc, be, br);
        end
    endtask

    initial begin
        test_reset();
        test_accept();
        test_code_change();
        test_glitch();
        test_reject();
        test_back_to_back();
        test_clear_accept();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
